// File: rtl/wb_commit_stage.sv
// wb_commit_stage: multi-lane writeback/commit with exception squash and an in-order pending-load queue.
// Define WB_DEBUG_TRACE_EN to drive the dbg_* trace outputs; otherwise they are tied to 0.
module wb_commit_stage #(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int LDQ_DEPTH = 4,
  parameter int ECODE_W   = 7
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       flush_i,
  input  logic [LANES-1:0]           in_valid,
  output logic                       in_ready,
  input  logic [LANES*XLEN-1:0]      in_pc,
  input  logic [LANES*32-1:0]        in_inst,
  input  logic [LANES-1:0]           in_we,
  input  logic [LANES*RA_W-1:0]      in_rd,
  input  logic [LANES*XLEN-1:0]      in_data,
  input  logic [LANES-1:0]           in_is_load,
  input  logic [LANES-1:0]           in_exc,
  input  logic [LANES*ECODE_W-1:0]   in_ecode,
  input  logic [LANES*XLEN-1:0]      in_badv,
  input  logic                       ld_resp_valid,
  input  logic [XLEN-1:0]            ld_resp_data,
  output logic [LANES:0]             wb_we,
  output logic [(LANES+1)*RA_W-1:0]  wb_rd,
  output logic [(LANES+1)*XLEN-1:0]  wb_data,
  output logic                       exc_valid,
  output logic [ECODE_W-1:0]         exc_ecode,
  output logic [XLEN-1:0]            exc_pc,
  output logic [XLEN-1:0]            exc_badv,
  output logic                       ldq_err,
  output logic [LANES-1:0]           dbg_valid,
  output logic [LANES*XLEN-1:0]      dbg_pc,
  output logic [LANES*32-1:0]        dbg_inst
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = $clog2(LDQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(LDQ_DEPTH);

  logic [RA_W-1:0]  r_q [LDQ_DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [LANES-1:0] w_live;
  logic [LANES-1:0] w_push;
  logic [CW-1:0]    w_pos [LANES];
  logic [CW-1:0]    w_nload;
  logic             w_hit;
  logic [ECODE_W-1:0] w_ecode;
  logic [XLEN-1:0]  w_epc;
  logic [XLEN-1:0]  w_ebadv;
  logic             w_pop;
  logic [CW:0]      w_room;
  logic             w_fire;

  // Find the oldest excepting lane; lanes before it are live, loads among them push.
  always_comb begin
    w_hit   = 1'b0;
    w_live  = '0;
    w_push  = '0;
    w_nload = '0;
    w_ecode = '0;
    w_epc   = '0;
    w_ebadv = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pos[i] = w_nload;
      if (in_valid[i] && !w_hit) begin
        if (in_exc[i]) begin
          w_hit   = 1'b1;
          w_ecode = in_ecode[i*ECODE_W +: ECODE_W];
          w_epc   = in_pc[i*XLEN +: XLEN];
          w_ebadv = in_badv[i*XLEN +: XLEN];
        end else begin
          w_live[i] = 1'b1;
          if (in_is_load[i]) begin
            w_push[i] = 1'b1;
            w_nload   = w_nload + CW'(1);
          end
        end
      end
    end
  end

  // A same-cycle pop frees one slot for the incoming group.
  always_comb begin
    w_pop    = ld_resp_valid && (r_count != '0);
    w_room   = DEPTH_V - {1'b0, r_count} + (CW+1)'(w_pop);
    in_ready = (w_room >= {1'b0, w_nload});
    w_fire   = (|in_valid) && in_ready && !flush_i;
  end

  // Queue storage: load destinations written at the tail in lane order.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_push[i])
          r_q[r_tail + PW'(w_pos[i])] <= in_rd[i*RA_W +: RA_W];
      end
    end
  end

  // Queue pointers, occupancy and the sticky empty-response error.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      ldq_err <= 1'b0;
    end else begin
      if (w_pop)
        r_head <= r_head + PW'(1);
      if (w_fire)
        r_tail <= r_tail + PW'(w_nload);
      r_count <= r_count + (w_fire ? w_nload : '0) - CW'(w_pop);
      if (ld_resp_valid && (r_count == '0))
        ldq_err <= 1'b1;
    end
  end

  // Register-file writes, load-port write and exception pulse.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wb_we     <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_ecode <= '0;
      exc_pc    <= '0;
      exc_badv  <= '0;
    end else begin
      wb_we     <= '0;
      exc_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (w_fire && w_live[i] && !in_is_load[i]) begin
          wb_we[i] <= in_we[i] && (in_rd[i*RA_W +: RA_W] != '0);
          wb_rd[i*RA_W +: RA_W]   <= in_rd[i*RA_W +: RA_W];
          wb_data[i*XLEN +: XLEN] <= in_data[i*XLEN +: XLEN];
        end
      end
      if (w_pop) begin
        wb_we[LANES] <= (r_q[r_head] != '0);
        wb_rd[LANES*RA_W +: RA_W]   <= r_q[r_head];
        wb_data[LANES*XLEN +: XLEN] <= ld_resp_data;
      end
      if (w_fire && w_hit) begin
        exc_valid <= 1'b1;
        exc_ecode <= w_ecode;
        exc_pc    <= w_epc;
        exc_badv  <= w_ebadv;
      end
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  // Commit trace: every live lane of an accepted group, loads included.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dbg_valid <= '0;
      dbg_pc    <= '0;
      dbg_inst  <= '0;
    end else begin
      dbg_valid <= w_fire ? w_live : '0;
      for (int i = 0; i < LANES; i++) begin
        if (w_fire && w_live[i]) begin
          dbg_pc[i*XLEN +: XLEN] <= in_pc[i*XLEN +: XLEN];
          dbg_inst[i*32 +: 32]   <= in_inst[i*32 +: 32];
        end
      end
    end
  end
`else
  assign dbg_valid = '0;
  assign dbg_pc    = '0;
  assign dbg_inst  = '0;
`endif

endmodule
